video2ram: RTL and testbench



---
 rtl/video2ram.sv | 147 ++++++++++++++
 tb/tb_video2ram.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/video2ram.sv
// Capture-side writer: turns the incoming pixel stream into line-buffer RAM writes and requests output start.
// Optional build macro VIDEO2RAM_TEST_PATTERN_EN replaces pixel data with a position-derived pattern.
module video2ram #(
  parameter int H_START      = 138,
  parameter int H_ACTIVE     = 640,
  parameter int V_START      = 35,
  parameter int V_START_LD   = 18,
  parameter int TRIGGER_LINE = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        line_doubler,
  output logic [11:0] wraddr,
  output logic [31:0] wrdata,
  output logic        wren,
  output logic        starttrigger
);

  typedef enum logic [1:0] {WAIT_VSYNC, CAPTURE, RUNNING} state_t;

  localparam logic [11:0] H_LO      = 12'(H_START);
  localparam logic [11:0] H_HI      = 12'(H_START + H_ACTIVE);
  localparam logic [9:0]  V_LO_FULL = 10'(V_START);
  localparam logic [9:0]  V_LO_LD   = 10'(V_START_LD);
  localparam logic [9:0]  TRIG_LN   = 10'(TRIGGER_LINE);

  state_t      state_reg, state_next;
  logic [7:0]  red_q_reg, green_q_reg, blue_q_reg;
  logic        hs_q_reg, vs_q_reg, hs_prev_reg, vs_prev_reg, ld_q_reg;
  logic [11:0] x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic [11:0] wraddr_reg, wraddr_next;
  logic [31:0] wrdata_reg, wrdata_next;
  logic        wren_reg, wren_next;
  logic        trig_reg, trig_next;

  logic        hs_fall, vs_fall, ld_change, visible;
  logic [9:0]  v_lo, v_hi, px, ln;
  logic [31:0] pix_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      red_q_reg   <= '0;
      green_q_reg <= '0;
      blue_q_reg  <= '0;
      hs_q_reg    <= 1'b1;
      vs_q_reg    <= 1'b1;
      hs_prev_reg <= 1'b1;
      vs_prev_reg <= 1'b1;
      ld_q_reg    <= 1'b0;
      state_reg   <= WAIT_VSYNC;
      x_reg       <= '0;
      y_reg       <= '0;
      wraddr_reg  <= '0;
      wrdata_reg  <= '0;
      wren_reg    <= 1'b0;
      trig_reg    <= 1'b0;
    end else begin
      red_q_reg   <= red;
      green_q_reg <= green;
      blue_q_reg  <= blue;
      hs_q_reg    <= hsync;
      vs_q_reg    <= vsync;
      hs_prev_reg <= hs_q_reg;
      vs_prev_reg <= vs_q_reg;
      ld_q_reg    <= line_doubler;
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      wraddr_reg  <= wraddr_next;
      wrdata_reg  <= wrdata_next;
      wren_reg    <= wren_next;
      trig_reg    <= trig_next;
    end
  end

  always_comb begin
    hs_fall   = hs_prev_reg & ~hs_q_reg;
    vs_fall   = vs_prev_reg & ~vs_q_reg;
    ld_change = line_doubler != ld_q_reg;

    // Counters saturate so a missing sync can never wrap back into the window.
    if (hs_fall)              x_next = '0;
    else if (x_reg == 12'hFFF) x_next = x_reg;
    else                       x_next = x_reg + 12'd1;

    if (vs_fall)                          y_next = '0;
    else if (hs_fall && y_reg != 10'h3FF) y_next = y_reg + 10'd1;
    else                                  y_next = y_reg;

    v_lo    = ld_q_reg ? V_LO_LD : V_LO_FULL;
    v_hi    = v_lo + (ld_q_reg ? 10'd240 : 10'd480);
    px      = 10'(x_next - H_LO);
    ln      = y_next - v_lo;
    visible = (x_next >= H_LO) && (x_next < H_HI) && (y_next >= v_lo) && (y_next < v_hi);

`ifdef VIDEO2RAM_TEST_PATTERN_EN
    pix_data = {px[7:0], ln[7:0], px[7:0] ^ ln[7:0], 8'h00};
`else
    pix_data = {red_q_reg, green_q_reg, blue_q_reg, 8'h00};
`endif

    state_next  = state_reg;
    trig_next   = trig_reg;
    wren_next   = 1'b0;
    wraddr_next = wraddr_reg;
    wrdata_next = wrdata_reg;

    unique case (state_reg)
      WAIT_VSYNC: if (vs_fall) state_next = CAPTURE;
      CAPTURE: begin
        if (hs_fall && !vs_fall && ln == TRIG_LN) begin
          state_next = RUNNING;
          trig_next  = 1'b1;
        end
      end
      RUNNING: trig_next = 1'b1;
      default: state_next = WAIT_VSYNC;
    endcase

    if (state_reg != WAIT_VSYNC && visible) begin
      wren_next   = 1'b1;
      wraddr_next = ld_q_reg ? {ln[1:0], px} : {2'b00, px};
      wrdata_next = pix_data;
    end

    // A source-mode switch invalidates the buffered geometry: restart from the next frame.
    if (ld_change) begin
      state_next = WAIT_VSYNC;
      trig_next  = 1'b0;
      wren_next  = 1'b0;
      x_next     = '0;
      y_next     = '0;
    end
  end

  assign wraddr       = wraddr_reg;
  assign wrdata       = wrdata_reg;
  assign wren         = wren_reg;
  assign starttrigger = trig_reg;

endmodule

// File: tb/tb_video2ram.sv
// Scoreboard bench for video2ram: stimulus pushes expected RAM writes, a negedge monitor pops and compares.
module tb_video2ram;

  localparam int HS = 6, HA = 12, VS = 3, VSLD = 2, TRIG = 2, LL = 24;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  red = '0, green = '0, blue = '0;
  logic        hsync = 1'b1, vsync = 1'b1, line_doubler = 1'b0;
  logic [11:0] wraddr;
  logic [31:0] wrdata;
  logic        wren, starttrigger;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  trig_mode = 0;   // 0 none, 1 expect rise at trig_line, 2 expect held high, 3 expect low
  int  trig_line = 0;

  video2ram #(
    .H_START(HS), .H_ACTIVE(HA), .V_START(VS), .V_START_LD(VSLD), .TRIGGER_LINE(TRIG)
  ) dut (
    .clock(clock), .reset(reset),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .line_doubler(line_doubler),
    .wraddr(wraddr), .wrdata(wrdata), .wren(wren), .starttrigger(starttrigger)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected write for pixel c of line k, if it lies in the active window.
  task automatic push_exp(input int k, input int c, input bit ld);
    int  vs0, va, px, ln;
    wr_t e;
    vs0 = ld ? VSLD : VS;
    va  = ld ? 240 : 480;
    if (c >= HS && c < HS + HA && k >= vs0 && k < vs0 + va) begin
      px = c - HS;
      ln = k - vs0;
      e.addr = ld ? {ln[1:0], 10'(px)} : {2'b00, 10'(px)};
`ifdef VIDEO2RAM_TEST_PATTERN_EN
      e.data = {8'(px), 8'(ln), 8'(px) ^ 8'(ln), 8'h00};
`else
      e.data = {8'(c), 8'(k), 8'(c) ^ 8'(k) ^ 8'h5A, 8'h00};
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic drive_pix(input int k, input int c, input bit vs_low);
    hsync = (c < 2) ? 1'b0 : 1'b1;
    vsync = vs_low ? 1'b0 : 1'b1;
    red   = 8'(c);
    green = 8'(k);
    blue  = 8'(c) ^ 8'(k) ^ 8'h5A;
  endtask

  task automatic run_line(input int k, input int len, input bit ld, input bit vs_low, input bit exp_wr);
    for (int c = 0; c < len; c++) begin
      drive_pix(k, c, vs_low);
      if (exp_wr) push_exp(k, c, ld);
      step();
      if (c == 0) begin
        if (trig_mode == 1 && k <= trig_line) check("trig_before", 32'(starttrigger), 32'd0);
        if (trig_mode == 2) check("trig_held", 32'(starttrigger), 32'd1);
        if (trig_mode == 3) check("trig_low", 32'(starttrigger), 32'd0);
      end
      if (c == 1 && trig_mode == 1 && k == trig_line)
        check("trig_rise", 32'(starttrigger), 32'd1);
    end
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge clock) begin
    wr_t e;
    if (reset && wren) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required none", wraddr, wrdata);
      end else begin
        e = exp_q.pop_front();
        if (wraddr !== e.addr || wrdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr=%h data=%h required addr=%h data=%h",
                   wraddr, wrdata, e.addr, e.data);
        end else begin
          $display("write addr=%h data=%h ok", wraddr, wrdata);
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) step();
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_trig", 32'(starttrigger), 32'd0);
    check("rst_addr", 32'(wraddr), 32'd0);
    check("rst_data", wrdata, 32'd0);
    reset = 1'b1;
    repeat (4) step();
    check("idle_wren", 32'(wren), 32'd0);

    // Frame A: 480-line source from WAIT; trigger rises at visible line TRIG
    trig_mode = 1;
    trig_line = VS + TRIG;
    for (int k = 0; k < VS + 483; k++) run_line(k, LL, 1'b0, k < 2, 1'b1);
    check("frameA_drained", 32'(exp_q.size()), 32'd0);

    // Frame B: trigger held across frames, then line_doubler toggles mid-line
    trig_mode = 2;
    for (int k = 0; k < 100; k++) run_line(k, LL, 1'b0, k < 2, 1'b1);
    for (int c = 0; c < LL; c++) begin
      drive_pix(100, c, 1'b0);
      if (c == HS + 4) line_doubler = 1'b1;
      if (c < HS + 3) push_exp(100, c, 1'b0);
      step();
      if (c == HS + 4) begin
        check("toggle_wren", 32'(wren), 32'd0);
        check("toggle_trig", 32'(starttrigger), 32'd0);
      end
    end
    trig_mode = 3;
    for (int k = 101; k < VS + 483; k++) run_line(k, LL, 1'b1, 1'b0, 1'b0);
    check("frameB_drained", 32'(exp_q.size()), 32'd0);

    // Frame C: 240-line source after the mode change
    trig_mode = 1;
    trig_line = VSLD + TRIG;
    for (int k = 0; k < VSLD + 243; k++) run_line(k, LL, 1'b1, k < 2, 1'b1);
    check("frameC_drained", 32'(exp_q.size()), 32'd0);

    // Frame D: a line with hsync missing for 5000 clocks, then mid-line reset
    trig_mode = 2;
    for (int k = 0; k < 10; k++) run_line(k, LL, 1'b1, k < 2, 1'b1);
    run_line(10, 5000, 1'b1, 1'b0, 1'b1);
    for (int k = 11; k < 21; k++) run_line(k, LL, 1'b1, 1'b0, 1'b1);
    check("frameD_drained", 32'(exp_q.size()), 32'd0);
    trig_mode = 0;
    for (int c = 0; c <= HS + 5; c++) begin
      drive_pix(21, c, 1'b0);
      push_exp(21, c, 1'b1);
      step();
    end
    check("pre_reset_wren", 32'(wren), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_wren", 32'(wren), 32'd0);
    check("async_rst_trig", 32'(starttrigger), 32'd0);
    check("async_rst_addr", 32'(wraddr), 32'd0);
    check("async_rst_data", wrdata, 32'd0);
    exp_q.delete();
    step();
    reset = 1'b1;
    for (int c = HS + 6; c < LL; c++) begin
      drive_pix(21, c, 1'b0);
      step();
    end
    check("post_rst_trig", 32'(starttrigger), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
